// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    // Shared with the TX block so both ends of the serial path agree on bit timing.
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_DATA_BITS    = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous pad inputs
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the reset value is chosen per pad so release looks idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// rtl/uart_rx_fifo_writer.sv - UART receiver pushing bytes into the shared FIFO
module uart_rx_fifo_writer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 Clock,
    input  logic                 Rst_n,
    input  logic                 Rx_Serial,
    input  logic                 f_full,
    input  logic                 Err_Clr,
    output logic                 Wr_En,
    output logic [DATA_BITS-1:0] Wr_Data,
    output logic                 Rx_DV,
    output logic                 Rx_Active,
    output logic                 Frame_Err,
    output logic                 Overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_ok;
    logic                 frame_bad;
    logic                 rx_dv_q;
    logic [DATA_BITS-1:0] wr_data_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    // Resets high so leaving reset never looks like a falling start edge.
    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (Clock),
        .rst_n (Rst_n),
        .d     (Rx_Serial),
        .q     (rx_s)
    );

    // Frame state, bit timer, bit index and shift register.
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Frame sequencing: mid-bit sampling, LSB-first shifting, stop-bit validation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_s == START_BIT) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (rx_s == START_BIT) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s == STOP_BIT) begin
                        frame_ok = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s == STOP_BIT) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Byte-valid pulse, held output byte and sticky flags (a set beats a same-cycle clear).
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_dv_q     <= 1'b0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_dv_q     <= frame_ok;
            if (frame_ok) begin
                wr_data_q <= shift_q;
            end
            frame_err_q <= frame_bad | (frame_err_q & ~Err_Clr);
            overrun_q   <= (rx_dv_q & f_full) | (overrun_q & ~Err_Clr);
        end
    end

    // f_full gates the write in the same cycle the byte is presented.
    assign Wr_En     = rx_dv_q & ~f_full;
    assign Wr_Data   = wr_data_q;
    assign Rx_DV     = rx_dv_q;
    assign Rx_Active = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign Frame_Err = frame_err_q;
    assign Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// tb/tb_uart_rx_fifo_writer.sv - randomized self-checking bench for uart_rx_fifo_writer
module tb_uart_rx_fifo_writer;

    localparam int CPB = 16;

    logic       Clock = 1'b0;
    logic       Rst_n;
    logic       Rx_Serial;
    logic       f_full;
    logic       Err_Clr;
    logic       Wr_En;
    logic [7:0] Wr_Data;
    logic       Rx_DV;
    logic       Rx_Active;
    logic       Frame_Err;
    logic       Overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] wr_q[$];
    int         wr_t[$];
    int         dv_cnt   = 0;
    int         act_cnt  = 0;
    int         wide_cnt = 0;
    logic       wr_prev  = 1'b0;

    uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .Clock     (Clock),
        .Rst_n     (Rst_n),
        .Rx_Serial (Rx_Serial),
        .f_full    (f_full),
        .Err_Clr   (Err_Clr),
        .Wr_En     (Wr_En),
        .Wr_Data   (Wr_Data),
        .Rx_DV     (Rx_DV),
        .Rx_Active (Rx_Active),
        .Frame_Err (Frame_Err),
        .Overrun   (Overrun)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc++;

    always @(negedge Clock) begin
        if (Wr_En === 1'b1) begin
            wr_q.push_back(Wr_Data);
            wr_t.push_back(cyc);
        end
        if (Wr_En === 1'b1 && wr_prev) wide_cnt++;
        wr_prev = (Wr_En === 1'b1);
        if (Rx_DV === 1'b1) dv_cnt++;
        if (Rx_Active === 1'b1) act_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        wr_t.delete();
        dv_cnt   = 0;
        act_cnt  = 0;
        wide_cnt = 0;
    endtask

    task automatic err_clr_pulse();
        Err_Clr = 1'b1;
        tick(1);
        Err_Clr = 1'b0;
    endtask

    // One 8N1 frame, LSB first; the line is left at the stop-bit value.
    task automatic send_frame(input logic [7:0] d, input logic stop_val, output int t0);
        t0 = cyc;
        Rx_Serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            Rx_Serial = d[i];
            tick(CPB);
        end
        Rx_Serial = stop_val;
        tick(CPB);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Rx_Serial = 1'b1; f_full = 1'b0; Err_Clr = 1'b0;
        tick(3);
        @(negedge Clock);
        checks++; if (Wr_En !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b want 0", Wr_En); end
        checks++; if (Rx_DV !== 1'b0) begin failures++; $display("FAIL reset_rx_dv: got %b want 0", Rx_DV); end
        checks++; if (Rx_Active !== 1'b0) begin failures++; $display("FAIL reset_rx_active: got %b want 0", Rx_Active); end
        checks++; if (Frame_Err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b want 0", Frame_Err); end
        checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", Overrun); end
        checks++; if (Wr_Data !== 8'h00) begin failures++; $display("FAIL reset_wr_data: got %h want 00", Wr_Data); end
        tick(1);
        Rst_n = 1'b1;
        clear_mon();
        tick(30);
        checks++; if (act_cnt != 0) begin failures++; $display("FAIL reset_release_active: got %0d active cycles want 0", act_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        int t0, tfirst, n, gap, lat;
        exp = {8'hA5, 8'h3C};
        for (int i = 0; i < 3; i++) exp.push_back(8'($urandom));
        n = exp.size();
        f_full = 1'b0;
        clear_mon();
        for (int i = 0; i < n; i++) begin
            send_frame(exp[i], 1'b1, t0);
            if (i == 0) tfirst = t0;
        end
        tick(40);
        checks++; if (wr_q.size() != n) begin failures++; $display("FAIL b2b_count: got %0d writes want %0d", wr_q.size(), n); end
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp[i]) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", i, wr_q[i], exp[i]); end
        end
        for (int i = 1; i < n && i < wr_t.size(); i++) begin
            gap = wr_t[i] - wr_t[i-1];
            checks++; if (gap < 158 || gap > 162) begin failures++; $display("FAIL b2b_spacing[%0d]: got %0d clocks want 160+-2", i, gap); end
        end
        if (wr_t.size() > 0) begin
            lat = wr_t[0] - tfirst;
            checks++; if (lat < 152 || lat > 156) begin failures++; $display("FAIL b2b_latency: got %0d clocks want 152..156", lat); end
        end
        checks++; if (wide_cnt != 0) begin failures++; $display("FAIL b2b_pulse_width: got %0d wide pulses want 0", wide_cnt); end
        checks++; if (dv_cnt != n) begin failures++; $display("FAIL b2b_rx_dv: got %0d pulses want %0d", dv_cnt, n); end
        @(negedge Clock);
        checks++; if (Frame_Err !== 1'b0 || Overrun !== 1'b0) begin failures++; $display("FAIL b2b_flags: got fe=%b ov=%b want 0 0", Frame_Err, Overrun); end
        tick(1);
    endtask

    task automatic test_frame_error();
        int t0;
        f_full = 1'b0;
        clear_mon();
        send_frame(8'h55, 1'b0, t0);
        @(negedge Clock);
        checks++; if (wr_q.size() != 0 || dv_cnt != 0) begin failures++; $display("FAIL ferr_no_write: got %0d writes %0d dv want 0 0", wr_q.size(), dv_cnt); end
        checks++; if (Frame_Err !== 1'b1) begin failures++; $display("FAIL ferr_flag: got %b want 1", Frame_Err); end
        tick(1);
        act_cnt = 0;
        tick(40 * CPB);
        checks++; if (act_cnt != 0) begin failures++; $display("FAIL ferr_low_hold_active: got %0d active cycles want 0", act_cnt); end
        Rx_Serial = 1'b1;
        tick(3 * CPB);
        send_frame(8'h0F, 1'b1, t0);
        tick(30);
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL ferr_recover_count: got %0d writes want 1", wr_q.size()); end
        else begin
            checks++; if (wr_q[0] !== 8'h0F) begin failures++; $display("FAIL ferr_recover_data: got %h want 0f", wr_q[0]); end
        end
        @(negedge Clock);
        checks++; if (Frame_Err !== 1'b1) begin failures++; $display("FAIL ferr_sticky: got %b want 1", Frame_Err); end
        tick(1);
        err_clr_pulse();
        @(negedge Clock);
        checks++; if (Frame_Err !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %b want 0", Frame_Err); end
        tick(1);
    endtask

    task automatic test_glitch();
        int t0;
        logic [7:0] d;
        clear_mon();
        Rx_Serial = 1'b0;
        tick(4);
        Rx_Serial = 1'b1;
        tick(40);
        checks++; if (dv_cnt != 0 || wr_q.size() != 0) begin failures++; $display("FAIL glitch_output: got %0d dv %0d writes want 0 0", dv_cnt, wr_q.size()); end
        checks++; if (act_cnt < 6 || act_cnt > 10) begin failures++; $display("FAIL glitch_active_len: got %0d cycles want 6..10", act_cnt); end
        @(negedge Clock);
        checks++; if (Rx_Active !== 1'b0) begin failures++; $display("FAIL glitch_active_end: got %b want 0", Rx_Active); end
        tick(1);
        d = 8'($urandom);
        clear_mon();
        send_frame(d, 1'b1, t0);
        tick(30);
        checks++; if (wr_q.size() != 1 || wr_q[0] !== d) begin failures++; $display("FAIL glitch_next_frame: got %0d writes first %h want 1 write %h", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'h00, d); end
    endtask

    task automatic test_overrun();
        int t0;
        bit got;
        clear_mon();
        f_full = 1'b1;
        send_frame(8'h81, 1'b1, t0);
        tick(30);
        checks++; if (dv_cnt != 1) begin failures++; $display("FAIL ovr_rx_dv: got %0d pulses want 1", dv_cnt); end
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL ovr_no_write: got %0d writes want 0", wr_q.size()); end
        @(negedge Clock);
        checks++; if (Overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b want 1", Overrun); end
        tick(1);
        err_clr_pulse();
        @(negedge Clock);
        checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b want 0", Overrun); end
        tick(1);
        got = 1'b0;
        fork
            send_frame(8'($urandom), 1'b1, t0);
            begin
                for (int i = 0; i < 400 && !got; i++) begin
                    @(negedge Clock);
                    if (Rx_DV === 1'b1) got = 1'b1;
                end
                if (got) begin
                    Err_Clr = 1'b1;
                    @(posedge Clock);
                    #1;
                    Err_Clr = 1'b0;
                end
            end
        join
        checks++; if (!got) begin failures++; $display("FAIL ovr_wait_dv: got no Rx_DV within 400 clocks want pulse"); end
        tick(5);
        @(negedge Clock);
        checks++; if (Overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_beats_clear: got %b want 1", Overrun); end
        tick(1);
        err_clr_pulse();
        f_full = 1'b0;
        tick(2);
    endtask

    task automatic test_random_full();
        logic [7:0] exp[$];
        logic [7:0] d;
        bit exp_ov;
        int t0;
        exp_ov = 1'b0;
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            f_full = 1'($urandom_range(0, 1));
            if (f_full) exp_ov = 1'b1;
            else exp.push_back(d);
            send_frame(d, 1'b1, t0);
        end
        f_full = 1'b0;
        tick(30);
        checks++; if (wr_q.size() != exp.size()) begin failures++; $display("FAIL rnd_count: got %0d writes want %0d", wr_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp[i]) begin failures++; $display("FAIL rnd_data[%0d]: got %h want %h", i, wr_q[i], exp[i]); end
        end
        checks++; if (dv_cnt != 6) begin failures++; $display("FAIL rnd_rx_dv: got %0d pulses want 6", dv_cnt); end
        @(negedge Clock);
        checks++; if (Overrun !== exp_ov) begin failures++; $display("FAIL rnd_overrun: got %b want %b", Overrun, exp_ov); end
        tick(1);
    endtask

    task automatic test_reset_midframe();
        int t0;
        f_full = 1'b1;
        Rx_Serial = 1'b0;
        tick(CPB);
        Rx_Serial = 1'b1;
        tick(4 * CPB + CPB / 2);
        Rst_n = 1'b0;
        tick(2);
        @(negedge Clock);
        checks++; if ({Wr_En, Rx_DV, Rx_Active, Frame_Err, Overrun} !== 5'b0) begin failures++; $display("FAIL rst_mid_outputs: got we=%b dv=%b act=%b fe=%b ov=%b want all 0", Wr_En, Rx_DV, Rx_Active, Frame_Err, Overrun); end
        checks++; if (Wr_Data !== 8'h00) begin failures++; $display("FAIL rst_mid_wr_data: got %h want 00", Wr_Data); end
        tick(3);
        f_full = 1'b0;
        Rst_n = 1'b1;
        clear_mon();
        tick(200);
        checks++; if (wr_q.size() != 0 || dv_cnt != 0) begin failures++; $display("FAIL rst_mid_partial: got %0d writes %0d dv want 0 0", wr_q.size(), dv_cnt); end
        send_frame(8'h12, 1'b1, t0);
        tick(30);
        checks++; if (wr_q.size() != 1 || wr_q[0] !== 8'h12) begin failures++; $display("FAIL rst_mid_next: got %0d writes first %h want 1 write 12", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'h00); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_overrun();
        test_random_full();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_writer.md
# uart_rx_fifo_writer

Receive-side UART deserializer that turns the `Rx_Serial` pin into bytes and pushes them into the shared hardware FIFO. It is the receive half of the serial path whose transmit half is driven out of the FIFO on `Tx_Serial`. The block adds framing-error detection, break handling and FIFO overrun reporting. It sits between the `Rx_Serial` pad and the FIFO write port, in the `Clock` domain.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200). Clocks per bit; must be ≥ 4.
- `DATA_BITS`, default 8. Data bits per frame; 8N1 framing only.
- `Clock`  in  1  system clock; all state is on the rising edge.
- `Rst_n`  in  1  asynchronous active-low reset.
- `Rx_Serial`  in  1  raw serial line, asynchronous, idle high.
- `f_full`  in  1  FIFO full flag, sampled combinationally.
- `Err_Clr`  in  1  one-cycle pulse; clears the sticky error flags.
- `Wr_En`  out  1  FIFO write strobe, one cycle wide.
- `Wr_Data`  out  DATA_BITS  byte to write; valid while `Wr_En` is high.
- `Rx_DV`  out  1  one-cycle pulse for every frame with a valid stop bit, whether or not the byte was written.
- `Rx_Active`  out  1  high while a frame is being received (states START, DATA, STOP).
- `Frame_Err`  out  1  sticky; set when a stop bit samples low.
- `Overrun`  out  1  sticky; set when a valid byte arrives while `f_full` is high.

## Operation
- `Rx_Serial` passes through a 2-flop synchronizer. All decisions use the synchronized value `rx_s`.
- State machine:
  - **IDLE**: when `rx_s`=0, go to START and clear the counter.
  - **START**: count to (CLKS_PER_BIT-1)/2, i.e. mid-bit.
    - If `rx_s` is still 0, go to DATA and clear the counter and the bit index.
    - Otherwise treat it as a glitch and return to IDLE with no output.
  - **DATA**: every CLKS_PER_BIT clocks, sample `rx_s` into the shift register, LSB first. After bit index DATA_BITS-1, go to STOP.
  - **STOP**: after CLKS_PER_BIT clocks, sample `rx_s`.
    - If 1: the frame is valid; return to IDLE.
    - If 0: set `Frame_Err`, drop the byte, and go to WAIT_HIGH.
  - **WAIT_HIGH** (break or line held low): stay until `rx_s`=1, then go to IDLE. No new start bit is accepted before that.
- On a valid frame, `Rx_DV`=1 for one cycle.
  - If `f_full`=0 in that cycle: `Wr_En`=1 and `Wr_Data` = the received byte.
  - If `f_full`=1: `Wr_En`=0, the byte is dropped, and `Overrun` is set.
- `Err_Clr` clears both sticky flags. If a set event happens in the same cycle as `Err_Clr`, the set wins.
- The counter width is $clog2(CLKS_PER_BIT). The counter resets to 0 on every state transition and on every data-bit sample, and never wraps within a state.

## Timing
- Reset values:
  - `Wr_En`=0, `Rx_DV`=0, `Rx_Active`=0, `Frame_Err`=0, `Overrun`=0.
  - `Wr_Data`=0 and the shift register = 0.
  - Synchronizer flops = 1 (idle line), so leaving reset never produces a false start.
  - State = IDLE.
- Reset asserted mid-frame aborts the frame immediately with no write. After release the block waits for a fresh falling edge.
- Latency:
  - Start bit detection lags the pad by 2 synchronizer clocks.
  - The stop-bit sample lands about 9.5 bit times (start + 8 data + half stop) after the falling edge.
  - `Rx_DV` and `Wr_En` assert in the clock after the stop-bit sample.
- `Wr_Data` holds its value from `Wr_En` until the next valid frame.
- Back-to-back frames: the block returns to IDLE at mid-stop-bit, so a start bit that immediately follows a stop bit is caught.
- Throughput is 1 byte per 10 bit times. `f_full` is the only backpressure, and there is no stall: the line cannot be paused.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - default `CLKS_PER_BIT`;
  - frame constants (start = 0, stop = 1).
- The `uart_pkg` defaults must match the TX block.
- One sub-module: `sync_2ff`, a 2-flop synchronizer with a reset-value parameter. It is reused by other pad inputs.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Send 0xA5 then 0x3C back to back, `f_full`=0 → two single-cycle `Wr_En` pulses with `Wr_Data`=0xA5 then 0x3C, 160 clocks apart (±2); no error flags.
- 0x55 with the stop bit driven low, then the line held low for 40 bit times, then high, then 0x0F → no write for 0x55 and `Frame_Err`=1; no frame starts during the low period; 0x0F is written correctly.
- 4-clock low glitch on an idle line → no `Rx_DV`, no `Rx_Active` after START aborts, state returns to IDLE.
- 0x81 received with `f_full`=1 → `Rx_DV` pulses, `Wr_En` stays 0, `Overrun`=1. `Err_Clr` pulse → `Overrun`=0. `Err_Clr` in the same cycle as a new overrun → `Overrun` stays 1.
- `Rst_n` asserted at data bit 4 of 0xFF, released, then 0x12 sent → all outputs 0 during reset, no write of a partial byte, 0x12 written.
